// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the P7 EX stage.
// Optional madd/maddu accumulate is compiled in with `define MDU_MADD_EN.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Handshake: start is a one-cycle accept pulse that only fires while busy is
  // low; busy then stays high for the op's fixed latency and HI/LO update on
  // the edge that drops it, so a new md/hilo op may issue once busy reads 0.

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;

  logic        is_mul;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] mul_res;
  logic        div_signed;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  assign start = (is_mul || is_div) && !flush && !busy_q;
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Sign-extended 64x64 product keeps only the low 64 bits, which equal the
  // true signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    mul_res = (op == OP_MULT) ? prod_s : prod_u;
`ifdef MDU_MADD_EN
    if (op == OP_MADD) begin
      mul_res = {hi_q, lo_q} + prod_s;
    end else if (op == OP_MADDU) begin
      mul_res = {hi_q, lo_q} + prod_u;
    end
`endif
  end

  // One unsigned divider on magnitudes; signs restored afterwards so that
  // 0x80000000 / -1 yields 0x80000000 rather than an overflow.
  always_comb begin
    div_signed = (op == OP_DIV);
    num   = (div_signed && a[31]) ? -a : a;
    den   = (div_signed && b[31]) ? -b : b;
    if (den == 32'd0) begin
      den = 32'd1;
    end
    q_mag = num / den;
    r_mag = num % den;
    quo   = (div_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem   = (div_signed && a[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    count_d   = count_q;
    busy_d    = busy_q;

    if (busy_q) begin
      // In-flight ops ignore flush: their instruction has already left EX.
      count_d = count_q - 4'd1;
      if (count_q == 4'd1) begin
        busy_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      busy_d = 1'b1;
      if (is_mul) begin
        pend_hi_d = mul_res[63:32];
        pend_lo_d = mul_res[31:0];
        pend_wr_d = 1'b1;
        count_d   = MULT_N;
      end else begin
        pend_hi_d = rem;
        pend_lo_d = quo;
        pend_wr_d = (b != 32'd0);
        count_d   = DIV_N;
      end
    end else if (!flush) begin
      if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      count_q   <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

endmodule
